// File: rtl/hamming_secded_stream_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming_secded_stream_decoder                                            |
// | Two-stage SECDED Hamming decoder on a valid/ready stream, with per-word   |
// | status and saturating error counters.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hamming_secded_stream_decoder #(
  parameter int DATA_W = 11,
  parameter int R      = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W+R:0]      in_code,
  input  logic                   in_correct_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_err_corr,
  output logic                   out_err_uncorr,
  output logic [R-1:0]           out_syndrome,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt
);

  localparam int CW = DATA_W + R + 1;
  localparam int HW = DATA_W + R;

  generate
    if ((2 ** R) < (HW + 1)) begin : g_check_r_small
      $error("hamming_secded_stream_decoder: 2**R must be >= DATA_W+R+1");
    end
    if ((2 ** (R - 1)) > HW) begin : g_check_r_large
      $error("hamming_secded_stream_decoder: R too large for DATA_W");
    end
  endgenerate

  // Position (1..HW) of the idx-th data bit: the idx-th non-power-of-2 position.
  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 1;
    for (int p = 1; p <= HW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  logic          adv;
  logic          s1_valid;
  logic [HW-1:0] s1_code;
  logic [R-1:0]  s1_syn;
  logic          s1_par;
  logic          s1_cen;

  logic [R-1:0]      syn_in;
  logic              par_in;
  logic              is_corr;
  logic              is_uncorr;
  logic [HW-1:0]     fixed;
  logic [DATA_W-1:0] fix_data;
  logic              out_hs;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_hs   = out_valid && out_ready;

  always_comb begin
    syn_in = '0;
    for (int p = 1; p <= HW; p++) begin
      if (in_code[p-1]) syn_in = syn_in ^ R'(p);
    end
    par_in = ^in_code;
  end

  // Odd overall parity marks a single error; its syndrome names the bit, or 0 for the parity bit.
  always_comb begin
    is_corr   = 1'b0;
    is_uncorr = 1'b0;
    fixed     = s1_code;
    if (s1_par) begin
      if (int'(s1_syn) <= HW) is_corr = 1'b1;
      else                    is_uncorr = 1'b1;
    end else if (s1_syn != '0) begin
      is_uncorr = 1'b1;
    end
    for (int p = 1; p <= HW; p++) begin
      if (is_corr && s1_cen && (int'(s1_syn) == p)) fixed[p-1] = ~fixed[p-1];
    end
    for (int i = 0; i < DATA_W; i++) begin
      fix_data[i] = fixed[data_pos(i)-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_code        <= '0;
      s1_syn         <= '0;
      s1_par         <= 1'b0;
      s1_cen         <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_err_corr   <= 1'b0;
      out_err_uncorr <= 1'b0;
      out_syndrome   <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_code <= in_code[HW-1:0];
        s1_syn  <= syn_in;
        s1_par  <= par_in;
        s1_cen  <= in_correct_en;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data       <= fix_data;
        out_err_corr   <= is_corr;
        out_err_uncorr <= is_uncorr;
        out_syndrome   <= s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_hs) begin
      if (out_err_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (out_err_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_stream_decoder.sv
`default_nettype none
// Scoreboard bench for hamming_secded_stream_decoder: directed vectors, stall
// patterns, random words, counter saturation (2-bit instance) and mid-stream reset.
module tb_hamming_secded_stream_decoder;

  localparam int DATA_W = 11;
  localparam int R      = 4;
  localparam int HW     = DATA_W + R;
  localparam int CW     = HW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
    logic [R-1:0]      syn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [CW-1:0] in_code = '0;
  logic in_correct_en = 1'b0;
  logic out_ready = 1'b0;
  logic cnt_clr = 1'b0;

  logic in_ready, out_valid, out_err_corr, out_err_uncorr;
  logic [DATA_W-1:0] out_data;
  logic [R-1:0] out_syndrome;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic in_ready_s, out_valid_s, out_err_corr_s, out_err_uncorr_s;
  logic [DATA_W-1:0] out_data_s;
  logic [R-1:0] out_syndrome_s;
  logic [1:0] corr_cnt_s, uncorr_cnt_s;

  hamming_secded_stream_decoder #(.DATA_W(DATA_W), .R(R), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_correct_en(in_correct_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err_corr(out_err_corr),
    .out_err_uncorr(out_err_uncorr), .out_syndrome(out_syndrome),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_stream_decoder #(.DATA_W(DATA_W), .R(R), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_code(in_code), .in_correct_en(in_correct_en), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_err_corr(out_err_corr_s),
    .out_err_uncorr(out_err_uncorr_s), .out_syndrome(out_syndrome_s),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int rmode = 0;
  int pat_i = 0;
  logic rst_req = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference decode straight from the code rules: syndrome = XOR of set positions.
  function automatic exp_t model(input logic [CW-1:0] code, input logic cen);
    exp_t e;
    int s;
    int par;
    int j;
    logic [CW-1:0] c;
    s = 0; par = 0; j = 0; c = code;
    for (int p = 1; p <= HW; p++) if (code[p-1]) s = s ^ p;
    for (int b = 0; b < CW; b++) par = par ^ int'(code[b]);
    e = '0;
    if (par == 1 && s <= HW) e.corr = 1'b1;
    else if (s != 0)         e.uncorr = 1'b1;
    if (e.corr && cen && s != 0) c[s-1] = ~c[s-1];
    for (int p = 1; p <= HW; p++) begin
      if ($countones(p) != 1) begin
        e.data[j] = c[p-1];
        j++;
      end
    end
    e.syn = R'(s);
    return e;
  endfunction

  task automatic tick(input logic v, input logic [CW-1:0] code, input logic cen,
                      input logic clr, output logic acc);
    @(negedge clk);
    #1;
    rst_n = rst_req;
    in_valid = v;
    in_code = code;
    in_correct_en = cen;
    cnt_clr = clr;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
    endcase
    pat_i++;
    #2;
    acc = v && in_ready && rst_n;
  endtask

  task automatic send(input logic [CW-1:0] code, input logic cen, input exp_t e,
                      input logic clr);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      tick(1'b1, code, cen, clr, acc);
      if (acc) q.push_back(e);
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input logic clr);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, clr, acc);
  endtask

  task automatic drain(input logic clr);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      idle(1, clr);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    idle(3, clr);
  endtask

  // Monitor: compares outputs against the queue and keeps counter models.
  initial begin
    exp_t e;
    exp_t held;
    logic hv;
    logic prev_rst;
    int mc, mu, mc2, mu2;
    hv = 1'b0; prev_rst = 1'b1; held = '0;
    mc = 0; mu = 0; mc2 = 0; mu2 = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        q.delete();
        mc = 0; mu = 0; mc2 = 0; mu2 = 0;
        hv = 1'b0;
        prev_rst = 1'b1;
      end else begin
        if (prev_rst) begin
          chk("reset_out_valid", int'(out_valid), 0);
          chk("reset_out_fields", int'({out_data, out_err_corr, out_err_uncorr, out_syndrome}), 0);
          prev_rst = 1'b0;
        end
        if (out_valid) chk("in_ready_stall", int'(in_ready), int'(out_ready));
        else           chk("in_ready_idle", int'(in_ready), 1);
        chk("corr_cnt", int'(corr_cnt), mc);
        chk("uncorr_cnt", int'(uncorr_cnt), mu);
        chk("corr_cnt_small", int'(corr_cnt_s), mc2);
        chk("uncorr_cnt_small", int'(uncorr_cnt_s), mu2);
        if (hv && out_valid)
          chk("stall_hold", int'({out_data, out_err_corr, out_err_uncorr, out_syndrome}), int'(held));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_data", int'(out_data), int'(e.data));
            chk("out_err_corr", int'(out_err_corr), int'(e.corr));
            chk("out_err_uncorr", int'(out_err_uncorr), int'(e.uncorr));
            chk("out_syndrome", int'(out_syndrome), int'(e.syn));
          end
          if (out_err_corr)   begin mc = (mc < 65535) ? mc + 1 : mc; mc2 = (mc2 < 3) ? mc2 + 1 : mc2; end
          if (out_err_uncorr) begin mu = (mu < 65535) ? mu + 1 : mu; mu2 = (mu2 < 3) ? mu2 + 1 : mu2; end
        end
        if (cnt_clr) begin
          mc = 0; mu = 0; mc2 = 0; mu2 = 0;
        end
        hv = out_valid && !out_ready;
        held = {out_data, out_err_corr, out_err_uncorr, out_syndrome};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] code;
    logic cen;
    int nf;
    rst_req = 1'b0;
    idle(3, 1'b0);
    rst_req = 1'b1;
    rmode = 0;

    send(16'hFFFF, 1'b1, {11'h7FF, 1'b0, 1'b0, 4'd0}, 1'b0);
    send(16'hFFEF, 1'b1, {11'h7FF, 1'b1, 1'b0, 4'd5}, 1'b0);
    send(16'h7FFF, 1'b1, {11'h7FF, 1'b1, 1'b0, 4'd0}, 1'b0);
    send(16'hFFFC, 1'b1, {11'h7FF, 1'b0, 1'b1, 4'd3}, 1'b0);
    send(16'h0004, 1'b0, {11'h001, 1'b1, 1'b0, 4'd3}, 1'b0);
    send(16'h0004, 1'b1, {11'h000, 1'b1, 1'b0, 4'd3}, 1'b0);
    drain(1'b0);
    chk("dir_corr_cnt", int'(corr_cnt), 4);
    chk("dir_uncorr_cnt", int'(uncorr_cnt), 1);
    chk("sat_corr_cnt_small", int'(corr_cnt_s), 3);

    send(16'hFFEF, 1'b1, {11'h7FF, 1'b1, 1'b0, 4'd5}, 1'b0);
    chk("sat_corr_cnt_small_hold", int'(corr_cnt_s), 3);
    for (int i = 0; i < 4; i++) send(16'hFFEF, 1'b1, {11'h7FF, 1'b1, 1'b0, 4'd5}, 1'b1);
    drain(1'b1);
    chk("clr_corr_cnt", int'(corr_cnt), 0);
    chk("clr_corr_cnt_small", int'(corr_cnt_s), 0);

    rmode = 2;
    pat_i = 0;
    for (int i = 0; i < 8; i++) begin
      code = CW'($urandom);
      cen = 1'($urandom_range(0, 1));
      send(code, cen, model(code, cen), 1'b0);
    end
    drain(1'b0);

    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        code = CW'($urandom);
      end else begin
        code = ($urandom_range(0, 1) == 0) ? '0 : '1;
        nf = $urandom_range(0, 2);
        for (int k = 0; k < nf; k++) code[$urandom_range(0, CW-1)] ^= 1'b1;
      end
      cen = ($urandom_range(0, 3) != 0);
      send(code, cen, model(code, cen), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 3) == 0) idle(1, 1'b0);
    end
    drain(1'b0);

    rmode = 0;
    send(16'hFFEF, 1'b1, {11'h7FF, 1'b1, 1'b0, 4'd5}, 1'b0);
    send(16'hFFFC, 1'b1, {11'h7FF, 1'b0, 1'b1, 4'd3}, 1'b0);
    rst_req = 1'b0;
    idle(1, 1'b0);
    rst_req = 1'b1;
    idle(4, 1'b0);
    chk("post_reset_corr_cnt", int'(corr_cnt), 0);
    chk("post_reset_uncorr_cnt", int'(uncorr_cnt), 0);
    send(16'h7FFF, 1'b1, {11'h7FF, 1'b1, 1'b0, 4'd0}, 1'b0);
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
